bnn_layer_sequencer: RTL and testbench
======================================

// Module: bnn_layer_sequencer
// PURPOSE
//   Time-multiplexes one XNOR/popcount binary neuron datapath across NUM_NEURONS
//   logical neurons to evaluate a full BNN layer for one input activation vector.
//   Holds per-neuron weight and threshold registers, which a host writes over a
//   config port. Accepts an activation vector by valid/ready, emits the layer's
//   binary output vector by valid/ready. Sits between the TT pin wrapper and the
//   neuron datapath.
// PARAMETERS
//   IN_W         8  activation/weight vector width (bits per neuron input)
//   NUM_NEURONS  8  logical neurons evaluated per layer pass (>=2)
//   (derived) THR_W = $clog2(IN_W+1); IDX_W = $clog2(NUM_NEURONS)
// PORTS
//   clk        in   1            single clock, rising edge
//   rst        in   1            asynchronous, active-high reset
//   cfg_we     in   1            config write strobe
//   cfg_sel    in   1            0 = weight[cfg_addr], 1 = threshold[cfg_addr]
//   cfg_addr   in   IDX_W        neuron index
//   cfg_data   in   IN_W         write data (threshold uses low THR_W bits)
//   in_valid   in   1            activation vector valid
//   in_ready   out  1            sequencer can accept a vector
//   in_data    in   IN_W         activation vector
//   out_valid  out  1            layer result valid
//   out_ready  in   1            consumer accepts result
//   out_data   out  NUM_NEURONS  bit k = output of neuron k
//   busy       out  1            high in any state other than IDLE
// BEHAVIOUR
//   Reset (async, any time incl. mid-pass): state=IDLE, all weights=0, all
//     thresholds=0, act reg=0, out_data=0, out_valid=0, busy=0, in_ready=1 on release.
//   Neuron k: pop = popcount(~(act ^ weight[k])) in 0..IN_W; bit = (pop >= thr[k]).
//     thr=0 always fires; thr>IN_W never fires. Compare is unsigned, THR_W bits.
//   FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE:
//     IDLE : in_ready=1. in_valid&in_ready at edge E0 -> capture act, idx=0, RUN.
//     RUN  : each cycle present weight[idx]; register pop_q/idx_q at the edge;
//            idx++. At the edge that issues idx=NUM_NEURONS-1 -> DRAIN.
//     DRAIN: last pop_q compared, bit written; -> DONE.
//     Result bit k written at edge E(k+2); out_valid rises after E(NUM_NEURONS+1)
//       (latency NUM_NEURONS+1 cycles accept->valid; 9 cycles at defaults).
//     DONE : out_valid=1, out_data stable until out_valid&out_ready -> IDLE.
//   in_ready=0 outside IDLE; no back-to-back overlap (next accept >= 1 cycle after
//     the out handshake). out_data holds the last result after DONE until next pass.
//   out_data bits not yet written during a pass hold previous-pass values;
//     only read out_data when out_valid=1.
//   Config writes accepted only when busy=0; cfg_we while busy is ignored (no
//     side effect). Write in the same cycle as an in-accept takes effect (IDLE).
//   idx saturates at NUM_NEURONS-1; never wraps inside a pass.
// STRUCTURE
//   Package bnn_pkg: state enum (IDLE,RUN,DRAIN,DONE), CFG_SEL_WEIGHT/THRESH
//     constants, THR_W helper function.
//   Sub-module bnn_xnor_popcount (combinational: act, weight -> pop[THR_W-1:0]);
//     sequencer owns the pop_q pipeline register, weight/threshold regs and FSM.
// TESTING
//   1 Reset then in_data=8'hA5, no config -> out_data=8'hFF after 9 cycles (thr=0).
//   2 w[0]=8'hFF,thr[0]=8; in=8'hFF -> bit0=1; in=8'hFE (pop 7) -> bit0=0.
//   3 w[k]=8'h0F, thr[k]=k for k=0..7; in=8'h0F (pop 8) -> 8'hFF; in=8'hF0
//     (pop 0) -> 8'h01; thr[3]=9 then in=8'h0F -> bit3=0.
//   4 Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable,
//     in_ready=0, in_valid ignored; release -> IDLE next cycle, in_ready=1.
//   5 cfg_we to w[2] during RUN -> ignored; result matches pre-write weights.
//   6 Assert rst at RUN idx=4 -> out_valid=0, busy=0, weights/thresholds=0;
//     a new pass then yields 8'hFF.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared types and constants for the BNN layer sequencer.
package bnn_pkg;

   // Sequencer FSM states
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   // Config port target select
   localparam logic CFG_SEL_WEIGHT = 1'b0;
   localparam logic CFG_SEL_THRESH = 1'b1;

   // Bits needed to hold a popcount of 0..in_w inclusive
   function automatic int thr_width(input int in_w);
      return $clog2(in_w + 1);
   endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational binary neuron core: popcount of the XNOR of activation and weight.
module bnn_xnor_popcount
   import bnn_pkg::*;
#(
   parameter int IN_W  = 8,
   parameter int THR_W = thr_width(IN_W)
) (
   input  logic [IN_W-1:0]  act,
   input  logic [IN_W-1:0]  weight,
   output logic [THR_W-1:0] pop
);

   logic [IN_W-1:0]  match_bits;
   logic [THR_W-1:0] pop_sum;

   assign match_bits = ~(act ^ weight);

   // Count agreeing bit positions between activation and weight
   always_comb begin
      pop_sum = '0;
      for (int i = 0; i < IN_W; i++) begin
         pop_sum = pop_sum + THR_W'(match_bits[i]);
      end
   end

   assign pop = pop_sum;

endmodule

// File: rtl/bnn_layer_sequencer.sv
// Time-multiplexes one XNOR/popcount neuron over NUM_NEURONS logical neurons,
// holding per-neuron weights/thresholds written by a host over the config port.
module bnn_layer_sequencer
   import bnn_pkg::*;
#(
   parameter int IN_W        = 8,
   parameter int NUM_NEURONS = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cfg_we,
   input  logic                           cfg_sel,
   input  logic [$clog2(NUM_NEURONS)-1:0] cfg_addr,
   input  logic [IN_W-1:0]                cfg_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [IN_W-1:0]                in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [NUM_NEURONS-1:0]         out_data,
   output logic                           busy
);

   localparam int THR_W = thr_width(IN_W);
   localparam int IDX_W = $clog2(NUM_NEURONS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NEURONS - 1);

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [IN_W-1:0]        act_q, act_d;
   logic [THR_W-1:0]       pop_q, pop_d;
   logic [IDX_W-1:0]       pidx_q, pidx_d;
   logic                   pvld_q, pvld_d;
   logic [NUM_NEURONS-1:0] out_data_q, out_data_d;

   logic [IN_W-1:0]        weight_q [NUM_NEURONS];
   logic [IN_W-1:0]        weight_d [NUM_NEURONS];
   logic [THR_W-1:0]       thr_q    [NUM_NEURONS];
   logic [THR_W-1:0]       thr_d    [NUM_NEURONS];

   logic [THR_W-1:0]       pop_now;

   // Shared neuron datapath, fed the weight of the neuron currently issued
   bnn_xnor_popcount #(
      .IN_W  (IN_W),
      .THR_W (THR_W)
   ) u_core (
      .act    (act_q),
      .weight (weight_q[idx_q]),
      .pop    (pop_now)
   );

   // Host config writes; only honoured while the sequencer is idle
   always_comb begin
      weight_d = weight_q;
      thr_d    = thr_q;
      if (cfg_we && (state_q == S_IDLE)) begin
         if (cfg_sel == CFG_SEL_WEIGHT) begin
            weight_d[cfg_addr] = cfg_data;
         end else begin
            thr_d[cfg_addr] = cfg_data[THR_W-1:0];
         end
      end
   end

   // Weight and threshold register file
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_NEURONS; k++) begin
            weight_q[k] <= '0;
            thr_q[k]    <= '0;
         end
      end else begin
         weight_q <= weight_d;
         thr_q    <= thr_d;
      end
   end

   // Next-state, issue index, popcount pipeline and result-bit writeback
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      act_d      = act_q;
      pop_d      = pop_q;
      pidx_d     = pidx_q;
      pvld_d     = 1'b0;
      out_data_d = out_data_q;

      // A registered popcount from the previous cycle resolves one output bit
      if (pvld_q) begin
         out_data_d[pidx_q] = (pop_q >= thr_q[pidx_q]);
      end

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               act_d   = in_data;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            pop_d  = pop_now;
            pidx_d = idx_q;
            pvld_d = 1'b1;
            // idx stops at the last neuron rather than wrapping
            if (idx_q == IDX_LAST) begin
               state_d = S_DRAIN;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DRAIN: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and datapath registers, all cleared by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         act_q      <= '0;
         pop_q      <= '0;
         pidx_q     <= '0;
         pvld_q     <= 1'b0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         act_q      <= act_d;
         pop_q      <= pop_d;
         pidx_q     <= pidx_d;
         pvld_q     <= pvld_d;
         out_data_q <= out_data_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Directed self-checking bench for bnn_layer_sequencer (IN_W=8, NUM_NEURONS=8).
module tb_bnn_layer_sequencer;

   logic       clk;
   logic       rst;
   logic       cfg_we;
   logic       cfg_sel;
   logic [2:0] cfg_addr;
   logic [7:0] cfg_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       busy;

   int tests;
   int fails;
   int cyc;

   bnn_layer_sequencer #(
      .IN_W        (8),
      .NUM_NEURONS (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_sel   (cfg_sel),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // All tasks start and end at a falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic cfg_write(input logic sel, input logic [2:0] addr, input logic [7:0] data);
      cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic start_pass(input logic [7:0] v, input string tag);
      in_data  = v;
      in_valid = 1'b1;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      cyc = 0;
   endtask

   task automatic wait_result(input logic [7:0] exp, input string tag);
      while (!out_valid && cyc < 40) tick();
      check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_latency"}, 32'(cyc), 32'd9);
      check({tag, "_out_data"}, 32'(out_data), 32'(exp));
   endtask

   task automatic finish_pass(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
   endtask

   task automatic run_pass(input logic [7:0] v, input logic [7:0] exp, input string tag);
      start_pass(v, tag);
      wait_result(exp, tag);
      finish_pass(tag);
   endtask

   initial begin
      tests = 0; fails = 0; cyc = 0;
      rst = 1'b1;
      cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 1: reset state, then unconfigured pass fires every neuron
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      run_pass(8'hA5, 8'hFF, "t1");

      // 2: neuron 0 threshold at the maximum popcount
      cfg_write(1'b0, 3'd0, 8'hFF);
      cfg_write(1'b1, 3'd0, 8'd8);
      run_pass(8'hFF, 8'hFF, "t2_pop8");
      run_pass(8'hFE, 8'hFE, "t2_pop7");

      // 3: per-neuron thresholds 0..7, then one above the maximum
      for (int k = 0; k < 8; k++) begin
         cfg_write(1'b0, 3'(k), 8'h0F);
         cfg_write(1'b1, 3'(k), 8'(k));
      end
      run_pass(8'h0F, 8'hFF, "t3_pop8");
      run_pass(8'hF0, 8'h01, "t3_pop0");
      cfg_write(1'b1, 3'd3, 8'd9);
      run_pass(8'h0F, 8'hF7, "t3_thr9");

      // 4: backpressure in DONE holds the result and blocks new input
      start_pass(8'h0F, "t4");
      wait_result(8'hF7, "t4");
      in_data  = 8'h00;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t4_hold_valid", 32'(out_valid), 32'd1);
         check("t4_hold_data", 32'(out_data), 32'hF7);
         check("t4_hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      finish_pass("t4");
      check("t4_busy_after", 32'(busy), 32'd0);
      check("t4_data_kept", 32'(out_data), 32'hF7);

      // 5: config write during RUN has no effect
      start_pass(8'h0F, "t5");
      check("t5_busy", 32'(busy), 32'd1);
      cfg_write(1'b0, 3'd2, 8'hF0);
      wait_result(8'hF7, "t5");
      finish_pass("t5");
      run_pass(8'h0F, 8'hF7, "t5_again");

      // 6: asynchronous reset mid-pass clears everything
      start_pass(8'h0F, "t6");
      repeat (4) tick();
      check("t6_busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("t6_rst_out_valid", 32'(out_valid), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_out_data", 32'(out_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("t6_in_ready", 32'(in_ready), 32'd1);
      run_pass(8'h5A, 8'hFF, "t6_thr0");
      // Thresholds at 8 expose any weight that survived reset
      for (int k = 0; k < 8; k++) cfg_write(1'b1, 3'(k), 8'd8);
      run_pass(8'h00, 8'hFF, "t6_w0_pop8");
      run_pass(8'h01, 8'h00, "t6_w0_pop7");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
